// File: rtl/module_fetch_controller.sv
// Multi-cycle instruction fetch sequencer: issues imem requests at the PC, holds the fetched word
// for decode, and strobes pc_update. Optional misaligned-fetch trap under FETCH_MISALIGN_TRAP_EN.
module module_fetch_controller #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_addr,
    input  logic            redirect,
    input  logic            stall,
    output logic            pc_update,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            bus_error,
    output logic [31:0]     fetch_count,
    output logic            trap,
    output logic [2:0]      fsm_state
);

    // Handshakes: a transfer happens on a rising edge where both sides are high
    // (imem_req && imem_ready, instr_valid && instr_ready && !stall). Once raised,
    // imem_req and imem_addr stay stable until imem_ready; instr_valid/instr stay stable until taken.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [XLEN-1:0]   req_addr;
    logic [CNT_W-1:0]  wait_cnt;
    logic              capture;
    logic              count_en;
    logic              latch_addr;
    logic              clr_wait;
    logic              inc_wait;
    logic              set_berr;
    logic              timeout_hit;
    logic              accept;
    logic              misaligned;
    logic [XLEN-1:0]   pc_aligned;

    assign pc_aligned  = {pc_addr[XLEN-1:2], 2'b00};
    assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);
    assign accept      = instr_ready && !stall;
    assign instr_valid = (state == S_HOLD);
    assign fsm_state   = state;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = (pc_addr[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (!reset) begin
            trap <= 1'b0;
        end else if (state == S_REQ && misaligned) begin
            trap <= 1'b1;
        end
    end
`else
    assign misaligned = 1'b0;
    assign trap       = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        imem_req   = 1'b0;
        imem_addr  = '0;
        pc_update  = 1'b0;
        capture    = 1'b0;
        count_en   = 1'b0;
        latch_addr = 1'b0;
        clr_wait   = 1'b0;
        inc_wait   = 1'b0;
        set_berr   = 1'b0;
        case (state)
            S_IDLE: state_nx = S_REQ;
            S_REQ: begin
                if (misaligned) begin
                    state_nx = S_ERR;
                end else begin
                    imem_req   = 1'b1;
                    imem_addr  = pc_aligned;
                    latch_addr = 1'b1;
                    clr_wait   = 1'b1;
                    if (redirect) begin
                        // The request is already on the bus; if it has not completed it must be drained.
                        pc_update = 1'b1;
                        state_nx  = imem_ready ? S_REQ : S_DRAIN;
                    end else if (imem_ready) begin
                        capture  = 1'b1;
                        state_nx = S_HOLD;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                pc_update = redirect;
                if (imem_ready) begin
                    capture  = !redirect;
                    state_nx = redirect ? S_REQ : S_HOLD;
                end else if (timeout_hit) begin
                    set_berr = 1'b1;
                    state_nx = S_ERR;
                end else begin
                    inc_wait = 1'b1;
                    state_nx = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect || accept) begin
                    pc_update = 1'b1;
                    count_en  = accept;
                    state_nx  = S_REQ;
                end
            end
            S_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                pc_update = redirect;
                if (imem_ready) begin
                    state_nx = S_REQ;
                end else if (timeout_hit) begin
                    set_berr = 1'b1;
                    state_nx = S_ERR;
                end else begin
                    inc_wait = 1'b1;
                end
            end
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            req_addr    <= '0;
            wait_cnt    <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            bus_error   <= 1'b0;
            fetch_count <= '0;
        end else begin
            state <= state_nx;
            if (latch_addr) begin
                req_addr <= pc_aligned;
            end
            if (clr_wait) begin
                wait_cnt <= '0;
            end else if (inc_wait) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            // The PC only moves on pc_update, so pc_addr still names the outstanding request here.
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc_addr;
            end
            if (set_berr) begin
                bus_error <= 1'b1;
            end
            if (count_en) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_module_fetch_controller.sv
// Directed bench for module_fetch_controller: a PC register and memory responder around the DUT,
// fetched words checked through an expected queue.
module tb_module_fetch_controller;

    localparam int XLEN     = 32;
    localparam int TIMEOUT  = 4;
    localparam int ST_IDLE  = 0;
    localparam int ST_REQ   = 1;
    localparam int ST_WAIT  = 2;
    localparam int ST_HOLD  = 3;
    localparam int ST_DRAIN = 4;
    localparam int ST_ERR   = 5;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [XLEN-1:0] pc_addr;
    logic            redirect = 1'b0;
    logic            stall = 1'b0;
    logic            pc_update;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready = 1'b0;
    logic [XLEN-1:0] imem_rdata = '0;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready = 1'b0;
    logic            bus_error;
    logic [31:0]     fetch_count;
    logic            trap;
    logic [2:0]      fsm_state;

    logic [XLEN-1:0]   pc_reg;
    logic [XLEN-1:0]   redirect_target = '0;
    logic [2*XLEN-1:0] exp_q[$];
    int                checks = 0;
    int                errors = 0;

    module_fetch_controller #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .pc_addr(pc_addr), .redirect(redirect), .stall(stall),
        .pc_update(pc_update), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .bus_error(bus_error),
        .fetch_count(fetch_count), .trap(trap), .fsm_state(fsm_state)
    );

    // Clock and the PC register the strobe drives
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset) begin
            pc_reg <= '0;
        end else if (pc_update) begin
            pc_reg <= redirect ? redirect_target : pc_reg + 32'd4;
        end
    end
    assign pc_addr = pc_reg;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h00500093;
        return {16'hC0DE, a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic rdy, input logic [31:0] rd, input logic iready,
                         input logic stl, input logic redir, input logic [31:0] tgt);
        @(negedge clock);
        imem_ready      = rdy;
        imem_rdata      = rd;
        instr_ready     = iready;
        stall           = stl;
        redirect        = redir;
        redirect_target = tgt;
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] data);
        exp_q.push_back({pc, data});
    endtask

    task automatic pop_chk(input string tag);
        logic [63:0] e;
        chk({tag, "_qsize"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_pc"}, instr_pc, e[63:32]);
            chk({tag, "_instr"}, instr, e[31:0]);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        #1;
        chk("rst_state", 32'(fsm_state), ST_IDLE);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_pcupd", 32'(pc_update), 0);
        chk("rst_berr", 32'(bus_error), 0);
        chk("rst_count", fetch_count, 0);
        chk("rst_trap", 32'(trap), 0);

        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("idle_state", 32'(fsm_state), ST_IDLE);

        // Zero-wait fetch at 0x0, immediate accept
        drive(1, mem_word(0), 1, 0, 0, 0);
        chk("f0_state", 32'(fsm_state), ST_REQ);
        chk("f0_req", 32'(imem_req), 1);
        chk("f0_addr", imem_addr, 32'h0);
        chk("f0_valid", 32'(instr_valid), 0);
        chk("f0_pcupd", 32'(pc_update), 0);
        push_exp(32'h0, mem_word(0));
        drive(0, 0, 1, 0, 0, 0);
        chk("f0_hold_valid", 32'(instr_valid), 1);
        chk("f0_hold_pcupd", 32'(pc_update), 1);
        pop_chk("f0");

        // Fetch at 0x4 with ready three cycles late
        drive(0, 0, 1, 0, 0, 0);
        chk("f4_req0", 32'(imem_req), 1);
        chk("f4_addr0", imem_addr, 32'h4);
        chk("f4_pcupd0", 32'(pc_update), 0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            chk("f4_wait_state", 32'(fsm_state), ST_WAIT);
            chk("f4_wait_req", 32'(imem_req), 1);
            chk("f4_wait_addr", imem_addr, 32'h4);
        end
        drive(1, 32'h00500093, 1, 0, 0, 0);
        chk("f4_rdy_req", 32'(imem_req), 1);
        chk("f4_rdy_addr", imem_addr, 32'h4);
        push_exp(32'h4, 32'h00500093);

        // Stall in HOLD for five cycles, then one accept
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, 0, 0);
            chk("stall_valid", 32'(instr_valid), 1);
            chk("stall_pcupd", 32'(pc_update), 0);
            chk("stall_instr", instr, 32'h00500093);
            chk("stall_pc", instr_pc, 32'h4);
        end
        drive(0, 0, 1, 0, 0, 0);
        chk("unstall_pcupd", 32'(pc_update), 1);
        pop_chk("f4");

        // Redirect while waiting: drain the stale response, refetch at 0x100
        drive(0, 0, 0, 0, 0, 0);
        chk("f8_addr", imem_addr, 32'h8);
        chk("f8_valid", 32'(instr_valid), 0);
        chk("count_2", fetch_count, 2);
        drive(0, 0, 0, 0, 1, 32'h100);
        chk("wait_redir_state", 32'(fsm_state), ST_WAIT);
        chk("wait_redir_pcupd", 32'(pc_update), 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("drain_state", 32'(fsm_state), ST_DRAIN);
        chk("drain_req", 32'(imem_req), 1);
        chk("drain_addr", imem_addr, 32'h8);
        chk("drain_pcupd", 32'(pc_update), 0);
        drive(1, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("drain_rdy_req", 32'(imem_req), 1);
        drive(1, mem_word(32'h100), 0, 0, 0, 0);
        chk("f100_state", 32'(fsm_state), ST_REQ);
        chk("f100_addr", imem_addr, 32'h100);
        chk("f100_valid", 32'(instr_valid), 0);
        push_exp(32'h100, mem_word(32'h100));

        // Redirect together with accept: single pulse, count still advances
        drive(0, 0, 1, 0, 1, 32'h200);
        chk("redacc_pcupd", 32'(pc_update), 1);
        chk("redacc_valid", 32'(instr_valid), 1);
        pop_chk("f100");

        // Redirect in REQ with ready: response discarded
        drive(1, 32'hBAD0BAD0, 0, 0, 1, 32'h300);
        chk("reqred_state", 32'(fsm_state), ST_REQ);
        chk("reqred_addr", imem_addr, 32'h200);
        chk("reqred_pcupd", 32'(pc_update), 1);
        chk("count_3", fetch_count, 3);
        drive(1, mem_word(32'h300), 0, 0, 0, 0);
        chk("f300_addr", imem_addr, 32'h300);
        chk("f300_pcupd", 32'(pc_update), 0);

        // Redirect overrides stall in HOLD, no count
        drive(0, 0, 1, 1, 1, 32'h102);
        chk("redstall_valid", 32'(instr_valid), 1);
        chk("redstall_pc", instr_pc, 32'h300);
        chk("redstall_instr", instr, mem_word(32'h300));
        chk("redstall_pcupd", 32'(pc_update), 1);

        // Misaligned PC 0x102
`ifdef FETCH_MISALIGN_TRAP_EN
        drive(1, mem_word(32'h100), 0, 0, 0, 0);
        chk("mis_req", 32'(imem_req), 0);
        chk("mis_pcupd", 32'(pc_update), 0);
        chk("mis_count", fetch_count, 3);
        drive(0, 0, 0, 0, 0, 0);
        chk("mis_state", 32'(fsm_state), ST_ERR);
        chk("mis_trap", 32'(trap), 1);
        chk("mis_req_err", 32'(imem_req), 0);
        chk("mis_berr", 32'(bus_error), 0);
`else
        drive(1, mem_word(32'h100), 0, 0, 0, 0);
        chk("mis_req", 32'(imem_req), 1);
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_trap", 32'(trap), 0);
        push_exp(32'h102, mem_word(32'h100));
        drive(0, 0, 1, 0, 0, 0);
        chk("mis_count", fetch_count, 3);
        chk("mis_pcupd", 32'(pc_update), 1);
        pop_chk("f102");
        drive(0, 0, 0, 0, 0, 0);
        chk("count_4", fetch_count, 4);
        chk("mis_next_req", 32'(imem_req), 1);
`endif

        // Reset mid-request clears everything
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("rst2_state", 32'(fsm_state), ST_IDLE);
        chk("rst2_req", 32'(imem_req), 0);
        chk("rst2_count", fetch_count, 0);
        chk("rst2_instr", instr, 0);
        chk("rst2_pc", instr_pc, 0);
        chk("rst2_trap", 32'(trap), 0);
        @(negedge clock);
        reset = 1'b1;

        // Timeout: four WAIT cycles without ready
        drive(0, 0, 0, 0, 0, 0);
        chk("to_req_state", 32'(fsm_state), ST_REQ);
        chk("to_req_addr", imem_addr, 32'h0);
        for (int i = 0; i < TIMEOUT; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("to_wait_state", 32'(fsm_state), ST_WAIT);
            chk("to_wait_req", 32'(imem_req), 1);
            chk("to_wait_berr", 32'(bus_error), 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("to_err_state", 32'(fsm_state), ST_ERR);
        chk("to_err_berr", 32'(bus_error), 1);
        chk("to_err_req", 32'(imem_req), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1234, 1, 0, 1, 32'h40);
            chk("err_berr", 32'(bus_error), 1);
            chk("err_pcupd", 32'(pc_update), 0);
            chk("err_req", 32'(imem_req), 0);
            chk("err_valid", 32'(instr_valid), 0);
        end
        @(negedge clock);
        reset = 1'b0;
        redirect = 1'b0;
        @(negedge clock);
        #1;
        chk("rst3_berr", 32'(bus_error), 0);
        chk("rst3_state", 32'(fsm_state), ST_IDLE);
        chk("q_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
